// File: rtl/store_rmw_unit.sv
// Store unit for a 64-bit data memory without byte enables: SD is written
// directly, narrower stores are read-modify-written on the aligned doubleword.
module store_rmw_unit #(
  parameter int N      = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [N-1:0]      req_data,
  input  logic [2:0]        funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [N-1:0]      mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [N-1:0]      mem_wdata,
  output logic [7:0]        store_mask,
  output logic              done,
  output logic              misaligned
);

  // Handshake: a request is taken in any cycle where req_valid && req_ready;
  // req_ready is high only in IDLE, so a store occupies the unit until its
  // done or misaligned pulse has been issued.
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT_R, S_WRITE, S_RESP_OK, S_RESP_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        mask_q, mask_d;
  logic [N-1:0]      shift_q, shift_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;

  logic [2:0]        off;
  logic [7:0]        mask_calc;
  logic              bad;
  logic [N-1:0]      bmask;

  always_comb begin
    off = req_addr[2:0];
    bad = 1'b0;
    case (funct3)
      3'b000: mask_calc = 8'h01 << off;
      3'b001: begin mask_calc = 8'h03 << off; bad = off[0];              end
      3'b010: begin mask_calc = 8'h0F << off; bad = (off[1:0] != 2'b00); end
      3'b011: begin mask_calc = 8'hFF;        bad = (off != 3'b000);     end
      default: begin mask_calc = 8'h00;       bad = 1'b1;                end
    endcase
  end

  // Byte-lane mask expanded to a bit mask for the merge.
  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++) begin
      bmask[8*i +: 8] = {8{mask_q[i]}};
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d  = {req_addr[ADDR_W-1:3], 3'b000};
          mask_d  = mask_calc;
          shift_d = req_data << {off, 3'b000};
          if (bad) begin
            state_d = S_RESP_ERR;
          end else if (funct3 == 3'b011) begin
            wdata_d = req_data;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_WAIT_R;
      S_WAIT_R: begin
        if (mem_rvalid) begin
          wdata_d = (mem_rdata & ~bmask) | (shift_q & bmask);
          state_d = S_WRITE;
        end
      end
      S_WRITE:    state_d = S_RESP_OK;
      S_RESP_OK:  state_d = S_IDLE;
      S_RESP_ERR: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    ready_d = (state_d == S_IDLE);
    re_d    = (state_d == S_READ);
    we_d    = (state_d == S_WRITE);
    done_d  = (state_d == S_RESP_OK);
    mis_d   = (state_d == S_RESP_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      shift_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      re_q    <= re_d;
      we_q    <= we_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign req_ready  = ready_q;
  assign mem_addr   = addr_q;
  assign mem_re     = re_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;
  assign store_mask = mask_q;
  assign done       = done_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed and random stores, cycle-accurate
// response timing, write-back data checked against an expected queue.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [2:0]  funct3 = '0;
  logic [63:0] mem_addr;
  logic        mem_re;
  logic [63:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  store_mask;
  logic        done;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  store_rmw_unit #(.N(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .funct3(funct3),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .store_mask(store_mask), .done(done), .misaligned(misaligned)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Driver: issues one store and records what the DUT does, cycle k = k-th
  // cycle after the accept edge. Memory read data appears dly cycles after
  // the cycle following mem_re.
  task automatic drive_store(
    input  logic [63:0] a, input logic [63:0] d, input logic [2:0] f3,
    input  logic [63:0] rd, input int dly,
    output int re_cnt, output int re_cyc, output int we_cnt, output int we_cyc,
    output int done_cyc, output int mis_cyc,
    output logic [63:0] w_addr, output logic [63:0] w_data,
    output logic [7:0] mask1, output logic [40:0] rdy_hist,
    output logic both, output logic tmo);
    int rv_cyc;
    re_cnt = 0; re_cyc = 0; we_cnt = 0; we_cyc = 0; done_cyc = 0; mis_cyc = 0;
    w_addr = '0; w_data = '0; mask1 = '0; rdy_hist = '0; both = 1'b0; tmo = 1'b1;
    rv_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    req_valid = 1'b1; req_addr = a; req_data = d; funct3 = f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = {$urandom, $urandom}; req_data = {$urandom, $urandom};
    funct3 = 3'($urandom_range(0, 7));
    for (int k = 1; k <= 40; k++) begin
      mem_rvalid = (k == rv_cyc);
      mem_rdata  = (k == rv_cyc) ? rd : {$urandom, $urandom};
      @(negedge clk);
      rdy_hist[k] = req_ready;
      if (k == 1) mask1 = store_mask;
      if (mem_re) begin
        re_cnt++; re_cyc = k;
        if (rv_cyc == 0) rv_cyc = k + 1 + dly;
      end
      if (mem_we) begin we_cnt++; we_cyc = k; w_addr = mem_addr; w_data = mem_wdata; end
      if (done) done_cyc = k;
      if (misaligned) mis_cyc = k;
      if (done && misaligned) both = 1'b1;
      if (done || misaligned) begin tmo = 1'b0; break; end
      @(posedge clk);
      #1;
    end
    mem_rvalid = 1'b0;
  endtask

  function automatic logic [63:0] model_write(input logic [2:0] off, input int sz,
                                              input logic [63:0] d, input logic [63:0] rd);
    logic [63:0] r;
    int nb;
    nb = 1 << sz;
    r = rd;
    for (int b = 0; b < 8; b++) begin
      if (b >= int'(off) && b < int'(off) + nb) r[8*b +: 8] = d[8*(b-int'(off)) +: 8];
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready, mem_re, mem_we, done, misaligned, store_mask, mem_addr, mem_wdata} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: ready=%b re=%b we=%b done=%b mis=%b mask=%h addr=%h wdata=%h, required all 0",
                 req_ready, mem_re, mem_we, done, misaligned, store_mask, mem_addr, mem_wdata);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_re, mem_we, done, misaligned, store_mask, mem_addr, mem_wdata} !== {1'b1, 140'b0}) begin
      n_err++;
      $display("FAIL after_reset: ready=%b re=%b we=%b done=%b mis=%b, required ready=1 others 0",
               req_ready, mem_re, mem_we, done, misaligned);
    end
    begin
      int strobes;
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (mem_re || mem_we || done || misaligned) strobes++;
      end
      n_cmp++;
      if (strobes !== 0) begin
        n_err++;
        $display("FAIL idle_quiet: %0d active cycles, required 0", strobes);
      end
    end
  endtask

  // Partial store with the shared read data; checks timing, mask and result.
  task automatic partial_case(input string nm, input logic [63:0] a, input logic [63:0] d,
                              input logic [2:0] f3, input int dly,
                              input logic [7:0] exp_mask, input logic [63:0] exp_w);
    int re_cnt, re_cyc, we_cnt, we_cyc, done_cyc, mis_cyc;
    logic [63:0] wa, wd;
    logic [7:0] m1;
    logic [40:0] rh;
    logic both, tmo;
    exp_q.push_back({64'h100, exp_w});
    drive_store(a, d, f3, 64'h807FFF00_1234569A, dly, re_cnt, re_cyc, we_cnt, we_cyc,
                done_cyc, mis_cyc, wa, wd, m1, rh, both, tmo);
    n_cmp++;
    if (tmo !== 1'b0) begin n_err++; $display("FAIL %s_timeout: no response within 40 cycles", nm); end
    n_cmp++;
    if ({re_cnt, re_cyc} !== {32'd1, 32'd1}) begin
      n_err++; $display("FAIL %s_read: %0d reads, last at T%0d, required 1 at T1", nm, re_cnt, re_cyc);
    end
    n_cmp++;
    if ({we_cnt, we_cyc, done_cyc, mis_cyc} !== {32'd1, 32'(3 + dly), 32'(4 + dly), 32'd0}) begin
      n_err++;
      $display("FAIL %s_timing: we=%0d@T%0d done@T%0d mis@T%0d, required we=1@T%0d done@T%0d mis none",
               nm, we_cnt, we_cyc, done_cyc, mis_cyc, 3 + dly, 4 + dly);
    end
    n_cmp++;
    if (m1 !== exp_mask) begin n_err++; $display("FAIL %s_mask: got %h required %h", nm, m1, exp_mask); end
    begin
      logic [127:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({wa, wd} !== e) begin
        n_err++; $display("FAIL %s_write: addr=%h data=%h required addr=%h data=%h", nm, wa, wd, e[127:64], e[63:0]);
      end
    end
  endtask

  task automatic test_partial();
    partial_case("sb",      64'h105, 64'hAB,       3'b000, 0, 8'h20, 64'h807FAB00_1234569A);
    partial_case("sh",      64'h106, 64'hBEEF,     3'b001, 0, 8'hC0, 64'hBEEFFF00_1234569A);
    partial_case("sw",      64'h104, 64'hDEADBEEF, 3'b010, 0, 8'hF0, 64'hDEADBEEF_1234569A);
    partial_case("sw_slow", 64'h104, 64'hDEADBEEF, 3'b010, 5, 8'hF0, 64'hDEADBEEF_1234569A);
  endtask

  task automatic sd_case(input string nm, input logic [63:0] a, input logic [63:0] d);
    int re_cnt, re_cyc, we_cnt, we_cyc, done_cyc, mis_cyc;
    logic [63:0] wa, wd;
    logic [7:0] m1;
    logic [40:0] rh;
    logic both, tmo;
    exp_q.push_back({a, d});
    drive_store(a, d, 3'b011, 64'h0, 0, re_cnt, re_cyc, we_cnt, we_cyc,
                done_cyc, mis_cyc, wa, wd, m1, rh, both, tmo);
    n_cmp++;
    if ({tmo, re_cnt, we_cnt, we_cyc, done_cyc} !== {1'b0, 32'd0, 32'd1, 32'd1, 32'd2}) begin
      n_err++;
      $display("FAIL %s_timing: tmo=%b reads=%0d we=%0d@T%0d done@T%0d, required reads=0 we=1@T1 done@T2",
               nm, tmo, re_cnt, we_cnt, we_cyc, done_cyc);
    end
    n_cmp++;
    if ({rh[1], rh[2], m1} !== {2'b00, 8'hFF}) begin
      n_err++; $display("FAIL %s_ready_mask: ready T1=%b T2=%b mask=%h, required 0 0 ff", nm, rh[1], rh[2], m1);
    end
    begin
      logic [127:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({wa, wd} !== e) begin
        n_err++; $display("FAIL %s_write: addr=%h data=%h required addr=%h data=%h", nm, wa, wd, e[127:64], e[63:0]);
      end
    end
  endtask

  task automatic test_sd();
    sd_case("sd", 64'h108, 64'h11223344_55667788);
  endtask

  task automatic mis_case(input string nm, input logic [63:0] a, input logic [2:0] f3);
    int re_cnt, re_cyc, we_cnt, we_cyc, done_cyc, mis_cyc;
    logic [63:0] wa, wd;
    logic [7:0] m1;
    logic [40:0] rh;
    logic both, tmo;
    drive_store(a, 64'hCAFE_F00D_1234_5678, f3, 64'h0, 0, re_cnt, re_cyc, we_cnt, we_cyc,
                done_cyc, mis_cyc, wa, wd, m1, rh, both, tmo);
    n_cmp++;
    if ({tmo, mis_cyc, re_cnt, we_cnt, done_cyc, both} !== {1'b0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: tmo=%b mis@T%0d reads=%0d writes=%0d done@T%0d both=%b, required mis@T1 nothing else",
               nm, tmo, mis_cyc, re_cnt, we_cnt, done_cyc, both);
    end
  endtask

  task automatic test_misaligned();
    mis_case("mis_sw",  64'h102, 3'b010);
    mis_case("mis_sh",  64'h103, 3'b001);
    mis_case("mis_sd",  64'h104, 3'b011);
    mis_case("mis_f3",  64'h100, 3'b100);
  endtask

  task automatic test_reset_midop();
    int bad_cnt;
    bad_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    req_valid = 1'b1; req_addr = 64'h105; req_data = 64'hAB; funct3 = 3'b000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_re !== 1'b1) begin n_err++; $display("FAIL midop_read: mem_re=%b required 1", mem_re); end
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h807FFF00_1234569A;
    #1;
    if (mem_we || done || req_ready) bad_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mem_we || done) bad_cnt++;
    end
    rst = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we || done || mem_re) bad_cnt++;
    end
    n_cmp++;
    if (bad_cnt !== 0) begin n_err++; $display("FAIL midop_abort: %0d cycles with activity, required 0", bad_cnt); end
    sd_case("sd_after_rst", 64'h2A0, 64'h0F0E0D0C_0B0A0908);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      int sz, dly, re_cnt, re_cyc, we_cnt, we_cyc, done_cyc, mis_cyc;
      logic [2:0] off;
      logic [63:0] base, d, rd, wa, wd;
      logic [7:0] m1;
      logic [40:0] rh;
      logic both, tmo;
      logic [127:0] e;
      sz   = $urandom_range(0, 3);
      off  = 3'(($urandom_range(0, 7) >> sz) << sz);
      base = {$urandom, $urandom} & ~64'h7;
      d    = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      dly  = $urandom_range(0, 3);
      exp_q.push_back({base, (sz == 3) ? d : model_write(off, sz, d, rd)});
      drive_store(base | 64'(off), d, 3'(sz), rd, dly, re_cnt, re_cyc, we_cnt, we_cyc,
                  done_cyc, mis_cyc, wa, wd, m1, rh, both, tmo);
      e = exp_q.pop_front();
      n_cmp++;
      if ({tmo, we_cnt, done_cyc, wa, wd} !== {1'b0, 32'd1, 32'((sz == 3) ? 2 : 4 + dly), e}) begin
        n_err++;
        $display("FAIL rand%0d: tmo=%b we=%0d done@T%0d addr=%h data=%h required done@T%0d addr=%h data=%h",
                 n, tmo, we_cnt, done_cyc, wa, wd, (sz == 3) ? 2 : 4 + dly, e[127:64], e[63:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_partial();
    test_sd();
    test_misaligned();
    test_reset_midop();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
